// File: rtl/bk_addsub_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control and status flags.
// Group G/P -> Brent-Kung prefix over groups -> in-group carries, cut into 1..3 register stages.
module bk_addsub_pipe #(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = 4,
    parameter int STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / GROUPSIZE;

    if ((GROUPSIZE < 1) || ((WIDTH % GROUPSIZE) != 0)) begin : g_bad_group
        $fatal(1, "bk_addsub_pipe: WIDTH must be a multiple of GROUPSIZE");
    end
    if ((NG & (NG - 1)) != 0) begin : g_bad_ng
        $fatal(1, "bk_addsub_pipe: WIDTH/GROUPSIZE must be a power of 2");
    end
    if ((STAGES < 1) || (STAGES > 3)) begin : g_bad_stages
        $fatal(1, "bk_addsub_pipe: STAGES must be 1..3");
    end

    // Returns {group_p, group_g}
    function automatic logic [2*NG-1:0] f_group(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic          bg;
        logic          bp;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < GROUPSIZE; i++) begin
                bg    = x[j*GROUPSIZE+i] & y[j*GROUPSIZE+i];
                bp    = x[j*GROUPSIZE+i] ^ y[j*GROUPSIZE+i];
                gg[j] = bg | (bp & gg[j]);
                gp[j] = gp[j] & bp;
            end
        end
        return {gp, gg};
    endfunction

    // Brent-Kung up-sweep/down-sweep, then fold in carry-in to get each group's carry-in
    function automatic logic [NG-1:0] f_prefix(input logic [NG-1:0] gg,
                                               input logic [NG-1:0] gp,
                                               input logic          cin);
        logic [NG-1:0] g;
        logic [NG-1:0] p;
        logic [NG-1:0] gc;
        g = gg;
        p = gp;
        for (int d = 1; d < NG; d = d * 2) begin
            for (int i = 2*d - 1; i < NG; i = i + 2*d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        for (int d = NG / 4; d >= 1; d = d / 2) begin
            for (int i = 3*d - 1; i < NG; i = i + 2*d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        gc[0] = cin;
        for (int j = 1; j < NG; j++) begin
            gc[j] = g[j-1] | (p[j-1] & cin);
        end
        return gc;
    endfunction

    // Returns {carry out of MSB, carry into MSB, sum}
    function automatic logic [WIDTH+1:0] f_final(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [NG-1:0]    gc);
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
        s  = '0;
        c  = 1'b0;
        cm = 1'b0;
        for (int j = 0; j < NG; j++) begin
            c = gc[j];
            for (int i = 0; i < GROUPSIZE; i++) begin
                s[j*GROUPSIZE+i] = x[j*GROUPSIZE+i] ^ y[j*GROUPSIZE+i] ^ c;
                if ((j*GROUPSIZE + i) == (WIDTH - 1)) begin
                    cm = c;
                end
                c = (x[j*GROUPSIZE+i] & y[j*GROUPSIZE+i]) |
                    ((x[j*GROUPSIZE+i] ^ y[j*GROUPSIZE+i]) & c);
            end
        end
        return {c, cm, s};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [NG-1:0]    gg_in;
    logic [NG-1:0]    gp_in;

    always_comb begin
        b_eff          = sub ? ~b : b;
        cin_eff        = sub | c_in;
        {gp_in, gg_in} = f_group(a, b_eff);
    end

    // en[k]: stage k may load this cycle; en[STAGES] is the downstream sink
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES:0]   v_chain;
    logic [STAGES:0]   en;

    assign v_chain = {v_q, in_valid};

    always_comb begin
        en         = '0;
        en[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en[k] = ~v_q[k] | en[k+1];
        end
        v_d = v_q;
        for (int k = 0; k < STAGES; k++) begin
            if (en[k]) begin
                v_d[k] = v_chain[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;
    logic [NG-1:0]    res_gc;

    if (STAGES == 1) begin : g_s1
        always_comb begin
            res_a  = a;
            res_b  = b_eff;
            res_gc = f_prefix(gg_in, gp_in, cin_eff);
        end
    end else begin : g_s23
        logic [WIDTH-1:0] a1_q, a1_d;
        logic [WIDTH-1:0] b1_q, b1_d;
        logic [NG-1:0]    gg1_q, gg1_d;
        logic [NG-1:0]    gp1_q, gp1_d;
        logic             cin1_q, cin1_d;

        always_comb begin
            a1_d   = a1_q;
            b1_d   = b1_q;
            gg1_d  = gg1_q;
            gp1_d  = gp1_q;
            cin1_d = cin1_q;
            if (en[0] & in_valid) begin
                a1_d   = a;
                b1_d   = b_eff;
                gg1_d  = gg_in;
                gp1_d  = gp_in;
                cin1_d = cin_eff;
            end
        end

        always_ff @(posedge clk) begin
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            gg1_q  <= gg1_d;
            gp1_q  <= gp1_d;
            cin1_q <= cin1_d;
        end

        if (STAGES == 2) begin : g_s2
            always_comb begin
                res_a  = a1_q;
                res_b  = b1_q;
                res_gc = f_prefix(gg1_q, gp1_q, cin1_q);
            end
        end else begin : g_s3
            logic [WIDTH-1:0] a2_q, a2_d;
            logic [WIDTH-1:0] b2_q, b2_d;
            logic [NG-1:0]    gc2_q, gc2_d;

            always_comb begin
                a2_d  = a2_q;
                b2_d  = b2_q;
                gc2_d = gc2_q;
                if (en[1] & v_q[0]) begin
                    a2_d  = a1_q;
                    b2_d  = b1_q;
                    gc2_d = f_prefix(gg1_q, gp1_q, cin1_q);
                end
            end

            always_ff @(posedge clk) begin
                a2_q  <= a2_d;
                b2_q  <= b2_d;
                gc2_q <= gc2_d;
            end

            always_comb begin
                res_a  = a2_q;
                res_b  = b2_q;
                res_gc = gc2_q;
            end
        end
    end

    logic [WIDTH+1:0] fin;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Output register only loads real results, so it holds the last one across bubbles
    always_comb begin
        fin     = f_final(res_a, res_b, res_gc);
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (en[STAGES-1] & v_chain[STAGES-1]) begin
            sum_d   = fin[WIDTH-1:0];
            c_out_d = fin[WIDTH+1];
            ovf_d   = fin[WIDTH+1] ^ fin[WIDTH];
            zero_d  = ~|fin[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_chain[STAGES];
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_bk_addsub_pipe.sv
// Directed bench for bk_addsub_pipe: arithmetic corners, back-pressure, streaming, mid-stream reset.
module tb_bk_addsub_pipe;
    localparam int WIDTH     = 32;
    localparam int GROUPSIZE = 4;
    localparam int STAGES    = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             c_in      = 1'b0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bk_addsub_pipe #(
        .WIDTH    (WIDTH),
        .GROUPSIZE(GROUPSIZE),
        .STAGES   (STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, c_out, sum}
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic s);
        logic [WIDTH-1:0] ye;
        logic [WIDTH:0]   r;
        logic             o;
        ye = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, (s | ci)};
        o  = (x[WIDTH-1] == ye[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return {o, r};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                          input logic ci, input logic s, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
        @(negedge clk);
        a = xa; b = xb; c_in = ci; sub = s; in_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(out_valid), 64'(STAGES == 1));
        repeat (STAGES - 1) @(negedge clk);
        chk(tag, {28'd0, out_valid, c_out, ovf, zero, sum}, {28'd0, 1'b1, ec, eo, ez, es});
    endtask

    initial begin
        int tx;
        int rx;
        int gaps;
        int nres;
        int stale;
        logic [WIDTH+1:0] e;
        logic [WIDTH+1:0] q[$];

        rst_n = 1'b0; in_valid = 1'b1; a = '1; b = '1;
        repeat (3) @(negedge clk);
        chk("rst_out", {28'd0, out_valid, c_out, ovf, zero, sum}, 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        rst_n = 1'b1; in_valid = 1'b0;

        run_op("max_plus1",  32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
        run_op("sub_borrow", 32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_pos",    32'h7,         32'h5,         1'b1, 1'b1, 32'h2,         1'b1, 1'b0, 1'b0);
        run_op("ovf_add",    32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("ovf_sub",    32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("cin_add",    32'h1,         32'h2,         1'b1, 1'b0, 32'h4,         1'b0, 1'b0, 1'b0);
        run_op("grp_carry",  32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        run_op("sub_zero",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1);
        run_op("neg_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1);
        run_op("cin_chain",  32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);

        // Back-pressure: 6 ops (i, i), sink stalled for the first 8 cycles
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 8);
            in_valid  = (tx < 6);
            a = WIDTH'(tx); b = WIDTH'(tx); c_in = 1'b0; sub = 1'b0;
            #1;
            if (cyc == 3 || cyc == 7) begin
                chk("bp_hold", {31'd0, out_valid, sum}, {31'd0, 1'b1, 32'd0});
                chk("bp_rdy_low", 64'(in_ready), 64'd0);
            end
            if (cyc == 7) chk("bp_accepts", 64'(tx), 64'(STAGES));
            if (out_valid && out_ready) begin
                chk("bp_order", 64'(sum), 64'(2 * rx));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        chk("bp_count", 64'(rx), 64'd6);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Streaming: 100 random ops, sink always ready
        tx = 0; gaps = 0; nres = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 + STAGES + 3; cyc++) begin
            @(negedge clk);
            in_valid = (tx < 100);
            a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
            #1;
            if (in_valid) chk("tp_rdy", 64'(in_ready), 64'd1);
            if (out_valid) begin
                if (q.size() > 0) e = q.pop_front();
                else e = '1;
                chk("tp_res", 64'({ovf, c_out, sum}), 64'(e));
                chk("tp_zero", 64'(zero), 64'(e[WIDTH-1:0] == '0));
                nres++;
            end else if (cyc >= STAGES && cyc < 100 + STAGES) begin
                gaps++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, c_in, sub));
                tx++;
            end
        end
        chk("tp_count", 64'(nres), 64'd100);
        chk("tp_gaps", 64'(gaps), 64'd0);

        // Reset with two ops held in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd10; b = 32'd20; c_in = 1'b0; sub = 1'b0;
        @(negedge clk);
        a = 32'd30; b = 32'd40;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs_inflight", {31'd0, out_valid, sum}, {31'd0, 1'b1, 32'd30});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_out", {28'd0, out_valid, c_out, ovf, zero, sum}, 64'd0);
        chk("rs_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rs_stale", 64'(stale), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
